uart_rx_ctrl: RTL



---
 rtl/uart_rx_ctrl_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive path: frame geometry and rx FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_rx_ctrl_pkg;

  // Data bits per frame; sipo must be built with the same value.
  localparam int DEF_DATA_WIDTH = 8;

  // os_tick pulses per bit period; must be even and at least 4 so that
  // the mid-start-bit point OVERSAMPLE/2-1 is a real count.
  localparam int DEF_OVERSAMPLE = 16;

  // Receiver FSM encodings (kept numeric for older code that decodes them).
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] STOP       = 3'd3;
  localparam logic [2:0] BREAK_WAIT = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous line.
// Latency: 2 clk cycles from async_in to sync_out.
// Backpressure: none; samples every cycle.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Both stages reset to 1 so a reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: finds start bit, strobes sipo once per data bit, checks stop bit.
// Latency: 2-cycle line synchronizer; shift/frame_done/frame_err one cycle after the deciding os_tick.
// Backpressure: none; the serial line cannot be stalled, all progress is paced by os_tick.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                            rx_clk,
  input  logic                            rst,
  input  logic                            rx_in,
  input  logic                            os_tick,
  output logic                            shift,
  output logic                            serial_bit,
  output logic                            frame_done,
  output logic                            frame_err,
  output logic                            busy,
  output logic [$clog2(DATA_WIDTH+1)-1:0] bit_idx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  // Start bit is checked half a bit in; every later sample is a full bit apart.
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;

  uart_rx_sync u_sync (
    .clk      (rx_clk),
    .rst      (rst),
    .async_in (rx_in),
    .sync_out (rx_s)
  );

  assign busy = (state != IDLE);

  // Frame sequencer: state, oversample counter, bit counter and registered strobes.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= 1'b0;
      serial_bit <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are only re-raised by a deciding tick below.
      shift      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (os_tick) begin
        case (state)
          IDLE: begin
            // bit_idx keeps the last frame's count until a new start appears.
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              bit_idx  <= '0;
            end
          end

          START: begin
            if (tick_cnt == MID_CNT) begin
              tick_cnt <= '0;
              // A line that is high again at mid start bit was noise.
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt   <= '0;
              shift      <= 1'b1;
              serial_bit <= rx_s;
              bit_idx    <= bit_idx + 1'b1;
              if (bit_idx == LAST_BIT) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          STOP: begin
            // Leaving at the stop-bit centre gives half a bit of margin
            // before a back-to-back start edge can arrive.
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              if (rx_s) begin
                frame_done <= 1'b1;
                state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK_WAIT;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          BREAK_WAIT: begin
            // A held-low line must return high before another start is accepted.
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
